hex_display_ctrl: RTL and testbench

- Display-update scheduler for the two-digit 7-segment readout.
- Arbitrates update requests from two requesters (A: note player, B: recorder/playback), captures the winner's 6-bit value and converts it to two BCD digits with a sequential shift-add-3 engine.
- Holds the digits stable for the downstream hexadecimaldisplay decoders, with optional leading-zero blanking of the tens digit.

---
 rtl/hex_display_ctrl_pkg.sv | 19 +
 rtl/hex_display_ctrl_if.sv | 31 +++
 rtl/hex_display_ctrl_bcd_add3.sv | 9 +
 rtl/hex_display_ctrl.sv | 115 +++++++++++
 tb/tb_hex_display_ctrl.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/hex_display_ctrl_pkg.sv
// hex_ctrl_pkg: shared definitions for the two-digit display-update scheduler.
//   state_e  : controller FSM encoding
//   W_DEF    : default binary input width (max value 63 -> two BCD digits)
//   GRANT_A/B: encoding of the round-robin "last granted" requester
package hex_ctrl_pkg;

  localparam int W_DEF = 6;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam logic GRANT_A = 1'b0;
  localparam logic GRANT_B = 1'b1;

endpackage

// File: rtl/hex_display_ctrl_if.sv
// hex_display_ctrl_if: request/ack handshake for requesters A and B plus the
// digit outputs toward the display decoders.
//   master : requester / observer side (drives req_*, data_*)
//   slave  : controller side (drives ack_*, busy, digits, blank_tens, valid)
interface hex_display_ctrl_if
  import hex_ctrl_pkg::*;
#(
  parameter int W = W_DEF
);
  logic         req_a;
  logic [W-1:0] data_a;
  logic         ack_a;
  logic         req_b;
  logic [W-1:0] data_b;
  logic         ack_b;
  logic         busy;
  logic [3:0]   digit_tens;
  logic [3:0]   digit_ones;
  logic         blank_tens;
  logic         valid;

  modport master (
    output req_a, data_a, req_b, data_b,
    input  ack_a, ack_b, busy, digit_tens, digit_ones, blank_tens, valid
  );

  modport slave (
    input  req_a, data_a, req_b, data_b,
    output ack_a, ack_b, busy, digit_tens, digit_ones, blank_tens, valid
  );
endinterface

// File: rtl/hex_display_ctrl_bcd_add3.sv
// bcd_add3: one correction step of the shift-add-3 binary-to-BCD conversion.
//   nib_i : BCD nibble before the shift
//   nib_o : nib_i + 3 when nib_i >= 5, else nib_i
module bcd_add3 (
  input  logic [3:0] nib_i,
  output logic [3:0] nib_o
);
  assign nib_o = (nib_i >= 4'd5) ? nib_i + 4'd3 : nib_i;
endmodule

// File: rtl/hex_display_ctrl.sv
// hex_display_ctrl: display-update scheduler. Round-robin arbitrates between
// requesters A and B, captures the winner's W-bit value, converts it to two
// BCD digits with a sequential shift-add-3 engine and holds the digits for the
// downstream 7-segment decoders.
//   Clock  : system clock, rising edge
//   Resetn : asynchronous active-low reset
//   bus    : slave side of hex_display_ctrl_if (req/data/ack for A and B,
//            busy, digit_tens, digit_ones, blank_tens, valid)
// Timeline from the sampling edge e0: ack in cycle after e0 (LOAD), W SHIFT
// cycles, DONE, digits update on edge e(W+2) and valid is high after it.
module hex_display_ctrl
  import hex_ctrl_pkg::*;
#(
  parameter int W        = W_DEF,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic             Clock,
  input  logic             Resetn,
  hex_display_ctrl_if.slave bus
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  state_e         state_q;
  logic [W-1:0]   sreg_q;
  logic [7:0]     acc_q;
  logic [CW-1:0]  cnt_q;
  logic           last_q;
  logic           ack_a_q, ack_b_q, busy_q, valid_q, blank_q;
  logic [3:0]     tens_q, ones_q;

  // Round-robin: B wins if it is the only requester, or on a tie when A won last.
  logic grant_b;
  assign grant_b = bus.req_b & (~bus.req_a | (last_q == GRANT_A));

  // Shift-add-3 datapath: correct both nibbles, then shift {tens, ones, sreg}.
  logic [1:0][3:0] nib_raw, nib_adj;
  logic [7:0]      acc_d;
  logic [W-1:0]    sreg_d;
  logic            unused_tens_msb;

  assign nib_raw = acc_q;

  for (genvar g = 0; g < 2; g++) begin : g_add3
    bcd_add3 u_add3 (.nib_i(nib_raw[g]), .nib_o(nib_adj[g]));
  end

  // The tens nibble never reaches 8 for W=6, so its corrected MSB is always
  // zero and is shifted out.
  assign unused_tens_msb = nib_adj[1][3];
  assign acc_d  = {nib_adj[1][2:0], nib_adj[0], sreg_q[W-1]};
  assign sreg_d = {sreg_q[W-2:0], 1'b0};

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= S_IDLE;
      sreg_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      last_q  <= GRANT_B;
      ack_a_q <= 1'b0;
      ack_b_q <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      tens_q  <= '0;
      ones_q  <= '0;
      blank_q <= BLANK_LZ;
    end else begin
      ack_a_q <= 1'b0;
      ack_b_q <= 1'b0;
      valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.req_a | bus.req_b) begin
            state_q <= S_LOAD;
            busy_q  <= 1'b1;
            sreg_q  <= grant_b ? bus.data_b : bus.data_a;
            acc_q   <= '0;
            last_q  <= grant_b;
            ack_a_q <= ~grant_b;
            ack_b_q <= grant_b;
          end
        end
        S_LOAD: begin
          state_q <= S_SHIFT;
          cnt_q   <= CW'(W - 1);
        end
        S_SHIFT: begin
          acc_q  <= acc_d;
          sreg_q <= sreg_d;
          cnt_q  <= cnt_q - 1'b1;
          if (cnt_q == '0) state_q <= S_DONE;
        end
        S_DONE: begin
          tens_q  <= acc_q[7:4];
          ones_q  <= acc_q[3:0];
          blank_q <= BLANK_LZ & (acc_q[7:4] == 4'd0);
          valid_q <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.ack_a      = ack_a_q;
  assign bus.ack_b      = ack_b_q;
  assign bus.busy       = busy_q;
  assign bus.valid      = valid_q;
  assign bus.digit_tens = tens_q;
  assign bus.digit_ones = ones_q;
  assign bus.blank_tens = blank_q;

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Directed bench for hex_display_ctrl; a second instance with BLANK_LZ=0 sees
// the same stimulus.
module tb_hex_display_ctrl;

  logic       Clock = 1'b0;
  logic       Resetn = 1'b0;
  logic       req_a = 1'b0, req_b = 1'b0;
  logic [5:0] data_a = '0, data_b = '0;
  bit         mon_en = 1'b0;
  int         n_chk = 0, n_fail = 0;

  always #5 Clock = ~Clock;

  hex_display_ctrl_if #(.W(6)) ifc ();
  hex_display_ctrl_if #(.W(6)) ifc0 ();

  assign ifc.req_a   = req_a;
  assign ifc.data_a  = data_a;
  assign ifc.req_b   = req_b;
  assign ifc.data_b  = data_b;
  assign ifc0.req_a  = req_a;
  assign ifc0.data_a = data_a;
  assign ifc0.req_b  = req_b;
  assign ifc0.data_b = data_b;

  hex_display_ctrl #(.W(6), .BLANK_LZ(1'b1)) u_dut (
    .Clock(Clock), .Resetn(Resetn), .bus(ifc.slave)
  );
  hex_display_ctrl #(.W(6), .BLANK_LZ(1'b0)) u_dut0 (
    .Clock(Clock), .Resetn(Resetn), .bus(ifc0.slave)
  );

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%0d exp=%0d", tag, act, exp);
    end
  endtask

  // Invariants: acks exclusive, valid never overlaps an ack.
  always @(negedge Clock) begin
    if (mon_en) begin
      chk("ack_excl", int'(ifc.ack_a & ifc.ack_b), 0);
      chk("vld_ack", int'(ifc.valid & (ifc.ack_a | ifc.ack_b)), 0);
    end
  end

  task automatic wait_ack(output int who, output int edges);
    edges = 0;
    who   = -1;
    do begin
      @(posedge Clock); @(negedge Clock);
      edges++;
    end while (!(ifc.ack_a | ifc.ack_b) && edges < 40);
    if (ifc.ack_a)      who = 0;
    else if (ifc.ack_b) who = 1;
    else chk("ack_timeout", 0, 1);
  endtask

  // Counts edges from the ack cycle to the first valid; also counts stray acks.
  task automatic wait_valid(output int lat, output int acks);
    lat  = 0;
    acks = 0;
    do begin
      @(posedge Clock); @(negedge Clock);
      lat++;
      if (ifc.ack_a | ifc.ack_b) acks++;
    end while (!ifc.valid && lat < 40);
    if (!ifc.valid) chk("valid_timeout", 0, 1);
  endtask

  task automatic serve(input bit use_b, input logic [5:0] v, input string tag);
    int who, e, lat, acks, vi;
    vi = int'(v);
    if (use_b) begin req_b = 1'b1; data_b = v; end
    else       begin req_a = 1'b1; data_a = v; end
    wait_ack(who, e);
    req_a = 1'b0;
    req_b = 1'b0;
    chk({tag, "_who"}, who, int'(use_b));
    chk({tag, "_acklat"}, e, 1);
    wait_valid(lat, acks);
    chk({tag, "_ackpulse"}, acks, 0);
    chk({tag, "_lat"}, lat, 8);
    chk({tag, "_tens"}, int'(ifc.digit_tens), vi / 10);
    chk({tag, "_ones"}, int'(ifc.digit_ones), vi % 10);
    chk({tag, "_blank"}, int'(ifc.blank_tens), (vi < 10) ? 1 : 0);
  endtask

  initial begin
    int who, e, lat, acks, expv;
    repeat (2) @(negedge Clock);
    chk("rst_tens",  int'(ifc.digit_tens), 0);
    chk("rst_ones",  int'(ifc.digit_ones), 0);
    chk("rst_blank", int'(ifc.blank_tens), 1);
    chk("rst_blank0", int'(ifc0.blank_tens), 0);
    chk("rst_busy",  int'(ifc.busy), 0);
    chk("rst_valid", int'(ifc.valid), 0);
    chk("rst_ack",   int'(ifc.ack_a | ifc.ack_b), 0);
    Resetn = 1'b1;
    @(negedge Clock);
    mon_en = 1'b1;

    serve(1'b0, 6'd63, "a63");
    serve(1'b1, 6'd7, "b7");
    chk("b7_blank0", int'(ifc0.blank_tens), 0);
    chk("b7_ones0",  int'(ifc0.digit_ones), 7);

    // Fresh reset so A wins the first tie; both requesters held throughout.
    Resetn = 1'b0;
    @(negedge Clock);
    Resetn = 1'b1;
    @(negedge Clock);
    req_a = 1'b1; data_a = 6'd12;
    req_b = 1'b1; data_b = 6'd45;
    for (int k = 0; k < 4; k++) begin
      wait_ack(who, e);
      chk($sformatf("rr%0d_who", k), who, k % 2);
      chk($sformatf("rr%0d_gap", k), e, 1);
      chk($sformatf("rr%0d_busy", k), int'(ifc.busy), 1);
      wait_valid(lat, acks);
      chk($sformatf("rr%0d_lat", k), lat, 8);
      expv = (k % 2 == 1) ? 45 : 12;
      chk($sformatf("rr%0d_tens", k), int'(ifc.digit_tens), expv / 10);
      chk($sformatf("rr%0d_ones", k), int'(ifc.digit_ones), expv % 10);
    end
    req_a = 1'b0;
    req_b = 1'b0;

    // Reset during the third SHIFT cycle discards the conversion.
    data_a = 6'd50;
    req_a  = 1'b1;
    wait_ack(who, e);
    req_a = 1'b0;
    repeat (3) @(posedge Clock);
    #2 Resetn = 1'b0;
    #1;
    chk("mid_tens",  int'(ifc.digit_tens), 0);
    chk("mid_ones",  int'(ifc.digit_ones), 0);
    chk("mid_busy",  int'(ifc.busy), 0);
    chk("mid_blank", int'(ifc.blank_tens), 1);
    chk("mid_valid", int'(ifc.valid), 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge Clock);
      chk("mid_hold_valid", int'(ifc.valid), 0);
    end
    Resetn = 1'b1;
    @(negedge Clock);
    serve(1'b0, 6'd50, "rst50");

    for (int v = 0; v < 64; v++) serve(1'b0, 6'(v), $sformatf("sw%0d", v));

    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
